// File: rtl/counter_4_bit_checker.sv
// -----------------------------------------------------------------------------
// counter_4_bit_checker
//
// Receiving-end monitor for a free-running up-counter bus. It samples the bus
// on qualified cycles and acquires lock after LOCK_LEN consecutive correct
// +1 steps (modulo 2^WIDTH). Once locked, every sample is checked. Mismatches
// are reported as a one-cycle err pulse and counted. Correctly checked
// all-ones-to-zero steps are counted as wraps.
//
// Optional feature: define CNT_CHK_STICKY_FAULT_EN to make a locked mismatch
// enter a sticky FAULT state. That state ignores samples and can be left
// only through rst_i. Without the macro, the checker falls back to SYNC and
// re-acquires lock on its own; fault_o is tied low.
//
// Parameters
//   WIDTH     width of the observed counter bus
//   LOCK_LEN  consecutive correct increments needed for lock (1..15)
//   CNT_W     width of the saturating error / wrap counters
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset, highest priority
//   count_in_i     observed counter value
//   count_valid_i  qualifies count_in_i this cycle
//   locked_o       high while locked
//   err_o          one-cycle pulse on a locked-state mismatch
//   fault_o        high in FAULT (constant 0 without the macro)
//   expected_o     next value the checker expects
//   err_count_o    saturating count of locked-state mismatches
//   wrap_count_o   saturating count of checked all-ones -> 0 steps
// -----------------------------------------------------------------------------
module counter_4_bit_checker #(
   parameter int WIDTH    = 4,
   parameter int LOCK_LEN = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] count_in_i,
   input  logic             count_valid_i,
   output logic             locked_o,
   output logic             err_o,
   output logic             fault_o,
   output logic [WIDTH-1:0] expected_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic [CNT_W-1:0] wrap_count_o
);

`ifdef CNT_CHK_STICKY_FAULT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_LOCKED, ST_FAULT} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_LOCKED} state_t;
`endif

   // One spare bit so that run+1 can be compared with LOCK_LEN without overflowing.
   localparam logic [4:0] LOCK_LEN_C = 5'(LOCK_LEN);

   state_t           state_q, state_d;
   logic [3:0]       run_q, run_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
`ifdef CNT_CHK_STICKY_FAULT_EN
   logic             fault_q, fault_d;
`endif

   logic [WIDTH-1:0] sample_inc;
   logic [4:0]       run_inc;
   logic             match;

   // The sum is truncated to WIDTH bits, so all-ones + 1 wraps to 0 as a
   // correct step in every state.
   assign sample_inc = count_in_i + WIDTH'(1);
   assign run_inc    = {1'b0, run_q} + 5'd1;
   assign match      = (count_in_i == expected_q);

   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      expected_d = expected_q;
      locked_d   = locked_q;
      err_d      = 1'b0;             // err is a pulse and drops on any non-reset cycle
      err_cnt_d  = err_cnt_q;
      wrap_cnt_d = wrap_cnt_q;
`ifdef CNT_CHK_STICKY_FAULT_EN
      fault_d    = fault_q;
`endif
      if (count_valid_i) begin
         case (state_q)
            ST_IDLE: begin
               expected_d = sample_inc;
               run_d      = 4'd0;
               state_d    = ST_SYNC;
            end
            ST_SYNC: begin
               // Noise while syncing only restarts the run. It is never reported.
               expected_d = sample_inc;
               if (match) begin
                  run_d = run_inc[3:0];
                  if (run_inc == LOCK_LEN_C) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  run_d = 4'd0;
               end
            end
            ST_LOCKED: begin
               if (match) begin
                  expected_d = sample_inc;
                  // A correct step into 0 means the previous sample was all-ones.
                  if (count_in_i == '0 && wrap_cnt_q != '1)
                     wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
               end else begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  if (err_cnt_q != '1)
                     err_cnt_d = err_cnt_q + CNT_W'(1);
`ifdef CNT_CHK_STICKY_FAULT_EN
                  // expected freezes at the value that was missed.
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
`else
                  state_d    = ST_SYNC;
                  expected_d = sample_inc;
                  run_d      = 4'd0;
`endif
               end
            end
            default: ;               // FAULT: samples ignored, only rst_i leaves
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         run_q      <= 4'd0;
         expected_q <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         wrap_cnt_q <= '0;
`ifdef CNT_CHK_STICKY_FAULT_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         expected_q <= expected_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
`ifdef CNT_CHK_STICKY_FAULT_EN
         fault_q    <= fault_d;
`endif
      end
   end

   assign locked_o     = locked_q;
   assign err_o        = err_q;
   assign expected_o   = expected_q;
   assign err_count_o  = err_cnt_q;
   assign wrap_count_o = wrap_cnt_q;
`ifdef CNT_CHK_STICKY_FAULT_EN
   assign fault_o = fault_q;
`else
   assign fault_o = 1'b0;
`endif

endmodule
